// File: rtl/float_sort_pkg.sv
// Shared definitions for the sort sequencer: FSM state codes and width/cycle helpers.
package float_sort_pkg;
   typedef logic [1:0] state_t;
   localparam state_t LOAD  = 2'd0;
   localparam state_t SORT  = 2'd1;
   localparam state_t DRAIN = 2'd2;

   // Counter width; a batch of 2 still needs one bit.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int sort_cycles(input int n);
      return n * (n - 1) / 2;
   endfunction

   localparam int N_DEFAULT   = 4;
   localparam int IDX_W       = idx_width(N_DEFAULT);
   localparam int SORT_CYCLES = sort_cycles(N_DEFAULT);
endpackage

// File: rtl/fp_config_pkg.sv
// Shared floating-point configuration: operand width for the FP datapath.
package fp_config_pkg;
   localparam int FLEN = 64;
endpackage

// File: rtl/f_less_or_equal.sv
// IEEE-754 a <= b comparator; err flags a NaN operand, -0 and +0 compare equal.
module f_less_or_equal #(
   parameter int W = 64
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         res,
   output logic         err
);
   localparam int EW = (W == 64) ? 11 : (W == 32) ? 8 : 5;
   localparam int MW = W - 1 - EW;

   logic [W-2:0] a_mag;
   logic [W-2:0] b_mag;
   logic         a_nan;
   logic         b_nan;
   logic         both_zero;

   assign a_mag     = a[W-2:0];
   assign b_mag     = b[W-2:0];
   assign a_nan     = (&a[W-2 -: EW]) && (|a[MW-1:0]);
   assign b_nan     = (&b[W-2 -: EW]) && (|b[MW-1:0]);
   assign both_zero = (a_mag == '0) && (b_mag == '0);

   // Sign-magnitude ordering: negative magnitudes compare reversed.
   always_comb begin
      err = a_nan || b_nan;
      res = 1'b0;
      if (err)
         res = 1'b0;
      else if (both_zero)
         res = 1'b1;
      else if (a[W-1] != b[W-1])
         res = a[W-1];
      else if (a[W-1])
         res = (a_mag >= b_mag);
      else
         res = (a_mag <= b_mag);
   end
endmodule

// File: rtl/float_sort_sequencer.sv
// Batch sorter: loads N values, bubble-sorts in place with one shared comparator, streams them out.
// Optional early exit on a swap-free pass: define FLOAT_SORT_SEQUENCER_EARLY_EXIT_EN.
module float_sort_sequencer
   import fp_config_pkg::*;
   import float_sort_pkg::*;
#(
   parameter int N = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            up_valid,
   output logic            up_ready,
   input  logic [FLEN-1:0] up_data,
   output logic            down_valid,
   input  logic            down_ready,
   output logic [FLEN-1:0] down_data,
   output logic            down_last,
   output logic            down_err,
   output logic            busy
);
   localparam int CW = idx_width(N);
   localparam logic [CW-1:0] LAST_IDX  = CW'(N - 1);
   localparam logic [CW-1:0] LAST_PASS = CW'(N - 2);

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   p;
   logic [CW-1:0]   i;
   logic            err_flag;
   logic [FLEN-1:0] vals [N];

   logic [CW-1:0]   i_next;
   logic [CW-1:0]   i_end;
   logic [FLEN-1:0] cmp_a;
   logic [FLEN-1:0] cmp_b;
   logic            res;
   logic            cmp_err;
   logic            in_sort;
   logic            do_swap;
   logic            pass_end;
   logic            sort_done;
   logic            load_hs;
   logic            drain_hs;

   assign i_next   = i + CW'(1);
   assign i_end    = LAST_PASS - p;
   assign cmp_a    = vals[i];
   assign cmp_b    = vals[i_next];
   assign in_sort  = (state == SORT);
   assign do_swap  = in_sort && !res && !cmp_err;
   assign pass_end = (i == i_end);
   assign load_hs  = (state == LOAD) && up_valid;
   assign drain_hs = (state == DRAIN) && down_ready;

   f_less_or_equal #(.W(FLEN)) u_cmp (
      .a   (cmp_a),
      .b   (cmp_b),
      .res (res),
      .err (cmp_err)
   );

`ifdef FLOAT_SORT_SEQUENCER_EARLY_EXIT_EN
   // An err compare counts as a swap so NaN batches always run every pass.
   logic swapped;
   assign sort_done = pass_end && ((p == LAST_PASS) || !(swapped || !res || cmp_err));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         swapped <= 1'b0;
      else if (!in_sort || pass_end)
         swapped <= 1'b0;
      else if (!res || cmp_err)
         swapped <= 1'b1;
   end
`else
   assign sort_done = pass_end && (p == LAST_PASS);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= LOAD;
         cnt      <= '0;
         p        <= '0;
         i        <= '0;
         err_flag <= 1'b0;
      end else begin
         case (state)
            LOAD: if (load_hs) begin
               if (cnt == LAST_IDX) begin
                  state    <= SORT;
                  cnt      <= '0;
                  p        <= '0;
                  i        <= '0;
                  err_flag <= 1'b0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            SORT: begin
               if (cmp_err)
                  err_flag <= 1'b1;
               if (sort_done) begin
                  state <= DRAIN;
                  i     <= '0;
                  p     <= '0;
               end else if (pass_end) begin
                  i <= '0;
                  p <= p + CW'(1);
               end else begin
                  i <= i_next;
               end
            end
            DRAIN: if (drain_hs) begin
               if (cnt == LAST_IDX) begin
                  state <= LOAD;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

   // Storage has no reset: it is only ever read after a full batch has been written.
   always_ff @(posedge clk) begin
      for (int k = 0; k < N; k++) begin
         if (load_hs && (cnt == CW'(k)))
            vals[k] <= up_data;
         else if (do_swap && (i == CW'(k)))
            vals[k] <= cmp_b;
         else if (do_swap && (i_next == CW'(k)))
            vals[k] <= cmp_a;
      end
   end

   assign up_ready   = (state == LOAD);
   assign down_valid = (state == DRAIN);
   assign down_data  = vals[cnt];
   assign down_last  = down_valid && (cnt == LAST_IDX);
   assign down_err   = down_valid && err_flag;
   assign busy       = (state != LOAD) || (cnt != '0);
endmodule

// File: tb/tb_float_sort_sequencer.sv
// Self-checking bench for float_sort_sequencer: directed and random batches against a stable-sort model.
`timescale 1ns/1ps
module tb_float_sort_sequencer;
   import fp_config_pkg::*;

   localparam int N = 4;
   localparam int SORT_CYC = N * (N - 1) / 2;

   typedef logic [FLEN-1:0] word_t;
   typedef struct {
      word_t data;
      bit    last;
      bit    err;
      bit    chk_data;
   } exp_t;

   logic  clk = 1'b0;
   logic  rst;
   logic  up_valid;
   logic  up_ready;
   word_t up_data;
   logic  down_valid;
   logic  down_ready;
   word_t down_data;
   logic  down_last;
   logic  down_err;
   logic  busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   float_sort_sequencer #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (up_valid),
      .up_ready   (up_ready),
      .up_data    (up_data),
      .down_valid (down_valid),
      .down_ready (down_ready),
      .down_data  (down_data),
      .down_last  (down_last),
      .down_err   (down_err),
      .busy       (busy)
   );

   exp_t  exp_q[$];
   word_t in_batch[$];
   int    samples = 0;
   int    hs_sample = 0;
   bit    awaiting_first = 1'b0;
   int    exp_lat = 0;
   bit    chk_lat = 1'b0;
   int    batch_lat = SORT_CYC + 1;
   bit    batch_lat_chk = 1'b1;
   bit    random_ready = 1'b0;
   bit    prev_stall = 1'b0;
   word_t prev_data = '0;
   bit    prev_last = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic finish_now();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   endtask

   function automatic bit is_nan(input word_t w);
      return (w[62:52] == 11'h7ff) && (w[51:0] != '0);
   endfunction

   // Reference: stable insertion sort on real value; err when any element is NaN.
   function automatic void ref_sort(input word_t v[N], output word_t s[N], output bit has_nan);
      word_t tmp;
      int    j;
      has_nan = 1'b0;
      for (int k = 0; k < N; k++) begin
         s[k] = v[k];
         if (is_nan(v[k])) has_nan = 1'b1;
      end
      if (!has_nan) begin
         for (int k = 1; k < N; k++) begin
            j = k;
            while (j > 0 && ($bitstoreal(s[j-1]) > $bitstoreal(s[j]))) begin
               tmp = s[j-1]; s[j-1] = s[j]; s[j] = tmp;
               j--;
            end
         end
      end
   endfunction

   function automatic word_t rand_val();
      word_t pool[8];
      word_t w;
      pool = '{64'h0, 64'h8000000000000000, 64'h3FF0000000000000, 64'hBFF0000000000000,
               64'h3FE0000000000000, 64'h4000000000000000, 64'hC00A000000000000, 64'h7FF0000000000000};
      if ($urandom_range(0, 1) == 0) begin
         w = pool[$urandom_range(0, 7)];
      end else begin
         w = {$urandom, $urandom};
         if (is_nan(w)) w[51:0] = '0;
      end
      return w;
   endfunction

   // Single compare process: model tracks handshakes and predicts every output cycle.
   always @(negedge clk) begin
      word_t v[N];
      word_t s[N];
      bit    hn;
      bit    outstanding;
      exp_t  e;
      samples++;
      if (rst) begin
         in_batch.delete();
         exp_q.delete();
         awaiting_first = 1'b0;
         prev_stall = 1'b0;
      end else begin
         outstanding = (exp_q.size() != 0);
         check("up_ready", up_ready, !outstanding);
         check("busy", busy, outstanding || (in_batch.size() != 0));
         if (prev_stall) check("valid_held", down_valid, 1);
         if (down_valid) begin
            if (!outstanding) begin
               check("unexpected_down_valid", down_valid, 0);
            end else begin
               if (awaiting_first) begin
                  awaiting_first = 1'b0;
                  if (chk_lat) check("latency", samples - hs_sample, exp_lat);
               end
               e = exp_q[0];
               if (e.chk_data) check("down_data", down_data, e.data);
               check("down_last", down_last, e.last);
               check("down_err", down_err, e.err);
               if (prev_stall) begin
                  check("stall_data", down_data, prev_data);
                  check("stall_last", down_last, prev_last);
               end
               if (down_ready) void'(exp_q.pop_front());
            end
            prev_stall = !down_ready;
            prev_data = down_data;
            prev_last = down_last;
         end else begin
            if (!outstanding) check("down_valid_idle", down_valid, 0);
            prev_stall = 1'b0;
         end
         if (up_valid && up_ready) begin
            in_batch.push_back(up_data);
            if (in_batch.size() == N) begin
               for (int k = 0; k < N; k++) v[k] = in_batch[k];
               ref_sort(v, s, hn);
               for (int k = 0; k < N; k++) begin
                  e.data = s[k];
                  e.last = (k == N - 1);
                  e.err = hn;
                  e.chk_data = !hn;
                  exp_q.push_back(e);
               end
               in_batch.delete();
               awaiting_first = 1'b1;
               hs_sample = samples;
               exp_lat = batch_lat;
               chk_lat = batch_lat_chk;
            end
         end
      end
   end

   initial begin
      down_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         down_ready = random_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
   end

   task automatic send_batch(input word_t v[N], input bit gaps);
      int t;
      for (int k = 0; k < N; k++) begin
         if (gaps) begin
            up_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         end
         up_valid = 1'b1;
         up_data = v[k];
         t = 0;
         @(negedge clk);
         while (!up_ready && t < 500) begin @(negedge clk); t++; end
         if (!up_ready) begin
            checks++; errors++;
            $display("FAIL up_ready_timeout: got 0 expected 1");
            finish_now();
         end
         @(posedge clk);
         #1;
      end
      up_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || in_batch.size() != 0) && t < 3000) begin @(negedge clk); t++; end
      if (t >= 3000) begin
         checks++; errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
         finish_now();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_up_ready"}, up_ready, 1);
      check({tag, "_down_valid"}, down_valid, 0);
      check({tag, "_down_last"}, down_last, 0);
      check({tag, "_down_err"}, down_err, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   word_t t_unsorted[N], t_sorted[N], t_dup[N], t_zero[N], t_nan[N], t_rand[N];
   word_t lit_zero[N], res_s[N];
   bit    res_nan;

   initial begin
      t_unsorted = '{64'h4000000000000000, 64'h3FF0000000000000, 64'hBFF0000000000000, 64'h3FE0000000000000};
      t_sorted   = '{64'hBFF0000000000000, 64'h3FE0000000000000, 64'h3FF0000000000000, 64'h4000000000000000};
      t_dup      = '{64'h3FF0000000000000, 64'h3FF0000000000000, 64'h3FE0000000000000, 64'h3FF0000000000000};
      t_zero     = '{64'h3FF0000000000000, 64'h8000000000000000, 64'h3FE0000000000000, 64'h0000000000000000};
      lit_zero   = '{64'h8000000000000000, 64'h0000000000000000, 64'h3FE0000000000000, 64'h3FF0000000000000};
      t_nan      = '{64'h3FF0000000000000, 64'h4000000000000000, 64'h7FF8000000000000, 64'h3FE0000000000000};

      rst = 1'b1; up_valid = 1'b0; up_data = '0;
      repeat (2) begin @(posedge clk); #1; end
      check_reset_outputs("reset");
      rst = 1'b0;

      // Pin the model against hand-sorted literals.
      ref_sort(t_unsorted, res_s, res_nan);
      for (int k = 0; k < N; k++) check("model_unsorted", res_s[k], t_sorted[k]);
      ref_sort(t_zero, res_s, res_nan);
      for (int k = 0; k < N; k++) check("model_signed_zero", res_s[k], lit_zero[k]);
      ref_sort(t_nan, res_s, res_nan);
      check("model_nan", res_nan, 1);

      batch_lat = 7; batch_lat_chk = 1'b1;
      send_batch(t_unsorted, 1'b0); wait_drain();
`ifdef FLOAT_SORT_SEQUENCER_EARLY_EXIT_EN
      batch_lat = N;
`else
      batch_lat = SORT_CYC + 1;
`endif
      send_batch(t_sorted, 1'b0); wait_drain();
      batch_lat = SORT_CYC + 1;
`ifdef FLOAT_SORT_SEQUENCER_EARLY_EXIT_EN
      batch_lat_chk = 1'b0;
`endif
      send_batch(t_dup, 1'b0); wait_drain();
      send_batch(t_zero, 1'b1); wait_drain();
      batch_lat_chk = 1'b1;
      send_batch(t_nan, 1'b0); wait_drain();
      send_batch(t_unsorted, 1'b0); wait_drain();

`ifdef FLOAT_SORT_SEQUENCER_EARLY_EXIT_EN
      batch_lat_chk = 1'b0;
`endif
      random_ready = 1'b1;
      for (int b = 0; b < 100; b++) begin
         for (int k = 0; k < N; k++) t_rand[k] = rand_val();
         send_batch(t_rand, 1'b1);
      end
      wait_drain();
      random_ready = 1'b0;

      // Reset during the third SORT cycle discards the batch.
      for (int k = 0; k < N; k++) t_rand[k] = rand_val();
      send_batch(t_rand, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("midsort_rst");
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < N; k++) t_rand[k] = rand_val();
      send_batch(t_rand, 1'b0);
      wait_drain();

      repeat (3) @(posedge clk);
      finish_now();
   end
endmodule

// File: doc/float_sort_sequencer.md
Name: float_sort_sequencer

Overview:
- Sorts a batch of N floating-point values into increasing order using a single shared f_less_or_equal comparator.
- The comparator is time-multiplexed over an in-place bubble sort, one compare-and-swap per cycle.
- Sits between an upstream producer and a downstream consumer, each with a valid/ready stream.
- Trades the N(N-1)/2 parallel comparators of a combinational sorting network for one comparator plus sequencing.

Parameters:
- N, 4, number of values per batch; legal range 2..16.
- FLEN is not a parameter. It comes from the shared config header (normally 64, FP64).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- up_valid  input  1  upstream value valid.
- up_ready  output  1  block can accept a value.
- up_data  input  FLEN  upstream value.
- down_valid  output  1  sorted value valid.
- down_ready  input  1  downstream can accept.
- down_data  output  FLEN  sorted value, smallest first.
- down_last  output  1  marks the N-th (largest) value of the batch.
- down_err  output  1  batch had at least one comparator err; held constant across the whole batch.
- busy  output  1  state is not LOAD, or the load count is nonzero.

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset values:
  - State = LOAD; load and drain counters = 0; pass p = 0; index i = 0; batch err flag = 0.
  - up_ready = 1; down_valid = 0; down_last = 0; down_err = 0; busy = 0.
  - Buffer contents are don't-care.
- State machine: LOAD -> SORT -> DRAIN -> LOAD.
- LOAD:
  - up_ready = 1, down_valid = 0.
  - Each handshake (up_valid & up_ready) writes buf[cnt] and increments cnt.
  - On the handshake with cnt == N-1, go to SORT with p = 0, i = 0, err flag = 0.
- SORT:
  - up_ready = 0. Each cycle the comparator sees a = buf[i], b = buf[i+1].
  - If res == 0 and err == 0, buf[i] and buf[i+1] swap at the clock edge. Otherwise no swap.
  - If err == 1, the batch err flag is set; it is sticky until the next LOAD entry.
  - Indexing: i increments. When i == N-2-p, set i = 0 and p = p+1.
  - When p == N-2 and i == 0 (the final compare), go to DRAIN.
  - The buffer is updated only through this swap path. Exactly N(N-1)/2 SORT cycles (6 for N = 4).
- DRAIN:
  - down_valid = 1; down_data = buf[cnt]; down_err = batch err flag.
  - down_last = (cnt == N-1).
  - cnt increments on each handshake (down_valid & down_ready).
  - The handshake with down_last goes to LOAD with cnt = 0.
  - down_data and down_last stay stable while down_valid & !down_ready.
- Latency:
  - Last input handshake at edge t.
  - SORT occupies cycles t+1 .. t+N(N-1)/2.
  - down_valid is first high in cycle t+N(N-1)/2+1.
- No overlap between batches: up_ready = 0 in SORT and DRAIN.
- Equal values never swap (res = 1), so the sort is stable.
- up_valid while up_ready = 0 is ignored; the producer must hold it.
- Reset asserted mid-SORT or mid-DRAIN:
  - Immediately returns to reset values; the partial batch is discarded.
  - No down_last is emitted for it.

Optional Feature:
- Macro: FLOAT_SORT_SEQUENCER_EARLY_EXIT_EN.
- Defined:
  - A per-pass swapped flag is cleared at each pass start and set by any swap.
  - At pass end, if the flag is 0, go directly to DRAIN.
  - Already-sorted input therefore takes N-1 SORT cycles.
  - An err compare also counts as "swapped", so a NaN batch always runs all passes.
- Undefined: fixed N(N-1)/2 SORT cycles, as above.

Decomposition:
- Package float_sort_pkg holds:
  - state enum (LOAD, SORT, DRAIN);
  - localparam IDX_W = $clog2(N) for cnt, i, p;
  - localparam SORT_CYCLES = N*(N-1)/2.
  - FLEN remains in the config header.
- One sub-module: f_less_or_equal, instantiated exactly once. Swap and mux logic stays inline in float_sort_sequencer.

Test Plan:
- N=4, FP64 input {4000000000000000 (2.0), 3FF0000000000000 (1.0), BFF0000000000000 (-1.0), 3FE0000000000000 (0.5)}, down_ready = 1.
  - Output: BFF0..., 3FE0..., 3FF0..., 4000...; down_last on the 4th; down_err = 0.
  - down_valid first high exactly 7 cycles after the last input handshake.
- Already-sorted {-1.0, 0.5, 1.0, 2.0}:
  - Output order unchanged; 6 SORT cycles.
  - With the EARLY_EXIT macro defined: 3 SORT cycles.
- Duplicates {1.0, 1.0, 0.5, 1.0} with input tags checked via a scoreboard:
  - Output 0.5, 1.0, 1.0, 1.0; equal values keep arrival order.
- NaN 7FF8000000000000 in position 2, others finite:
  - down_err = 1 on all 4 outputs.
  - Next clean batch has down_err = 0.
- Random down_ready (50%) over 100 random batches:
  - down_data stable while stalled; up_ready = 0 throughout SORT and DRAIN.
  - Output matches the reference sort.
- rst pulse during SORT cycle 3, then a new batch:
  - All outputs at reset values in the same cycle as rst rises.
  - Only the new batch appears on the output, correctly sorted.
